// File: rtl/ex_stage.sv
// ex_stage: MIPS execute stage with ALU, HI/LO registers and a 32-cycle iterative divider
// Ports:
//   clk, rst          - clock and synchronous active-high reset
//   stall             - pipeline stall vector (bit 2 = EX, bit 3 = MEM; 1 = stop)
//   id_to_ex_bus      - decoded instruction from the decode stage
//   ex_to_mem_bus     - {pc, data_ram_en, data_ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result}
//   ex_to_rf_bus      - {rf_we, rf_waddr, ex_result} forwarded back to decode
//   ex_is_load        - registered instruction is a load
//   stallreq_for_ex   - freeze request while a divide is starting or in flight
//   data_sram_*       - data SRAM request driven from the registered instruction
module ex_stage #(
    parameter int ID_TO_EX_WD  = 159,
    parameter int EX_TO_MEM_WD = 76,
    parameter int EX_TO_RF_WD  = 38,
    parameter int StallBus     = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [StallBus-1:0]     stall,
    input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
    output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
    output logic                    ex_is_load,
    output logic                    stallreq_for_ex,
    output logic                    data_sram_en,
    output logic [3:0]              data_sram_wen,
    output logic [31:0]             data_sram_addr,
    output logic [31:0]             data_sram_wdata
);
    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
    logic [ID_TO_EX_WD-1:0] id_ex_q, id_ex_d;
    logic [31:0] pc, inst, rdata1, rdata2;
    logic [11:0] alu_op;
    logic [2:0]  sel_src1;
    logic [3:0]  sel_src2, ram_wen;
    logic        ram_en, rf_we, sel_rf_res;
    logic [4:0]  rf_waddr;
    assign {pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen, rf_we, rf_waddr, sel_rf_res,
            rdata1, rdata2} = id_ex_q;
    logic [31:0] op1, op2, alu_res, ex_result;
    assign op1 = ({32{sel_src1[0]}} & rdata1) | ({32{sel_src1[1]}} & pc)
               | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
    assign op2 = ({32{sel_src2[0]}} & rdata2) | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
               | ({32{sel_src2[2]}} & 32'd8) | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});
    assign alu_res = ({32{alu_op[11]}} & (op1 + op2))
                   | ({32{alu_op[10]}} & (op1 - op2))
                   | ({32{alu_op[9]}}  & {31'b0, $signed(op1) < $signed(op2)})
                   | ({32{alu_op[8]}}  & {31'b0, op1 < op2})
                   | ({32{alu_op[7]}}  & (op1 & op2))
                   | ({32{alu_op[6]}}  & ~(op1 | op2))
                   | ({32{alu_op[5]}}  & (op1 | op2))
                   | ({32{alu_op[4]}}  & (op1 ^ op2))
                   | ({32{alu_op[3]}}  & (op2 << op1[4:0]))
                   | ({32{alu_op[2]}}  & (op2 >> op1[4:0]))
                   | ({32{alu_op[1]}}  & $unsigned($signed(op2) >>> op1[4:0]))
                   | ({32{alu_op[0]}}  & {op2[15:0], 16'b0});
    logic sp, is_mfhi, is_mflo, is_mthi, is_mtlo, is_div, div_op;
    assign sp      = inst[31:26] == 6'b0;
    assign is_mfhi = sp && inst[5:0] == 6'b010000;
    assign is_mflo = sp && inst[5:0] == 6'b010010;
    assign is_mthi = sp && inst[5:0] == 6'b010001;
    assign is_mtlo = sp && inst[5:0] == 6'b010011;
    assign is_div  = sp && inst[5:0] == 6'b011010;
    assign div_op  = is_div || (sp && inst[5:0] == 6'b011011);
    logic [1:0]  st_q, st_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, hi_q, hi_d, lo_q, lo_d;
    logic        nq_q, nq_d, nr_q, nr_d;
    logic        div_load, div_zero, div_fin;
    // Magnitudes for the unsigned core; signs are reapplied when the result is written.
    logic        a_neg, b_neg;
    logic [31:0] mag_a, mag_b;
    assign a_neg = is_div && rdata1[31];
    assign b_neg = is_div && rdata2[31];
    assign mag_a = a_neg ? -rdata1 : rdata1;
    assign mag_b = b_neg ? -rdata2 : rdata2;
    // Restoring step: the shifted partial remainder never exceeds 2*divisor-1, so bit 32 of
    // the difference is a reliable borrow flag.
    logic [32:0] shifted, diff;
    logic [31:0] step_rem, step_quo;
    assign shifted  = {rem_q, quo_q[31]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign step_rem = diff[32] ? shifted[31:0] : diff[31:0];
    assign step_quo = {quo_q[30:0], ~diff[32]};
    always_ff @(posedge clk) begin
        if (rst) st_q <= IDLE;
        else     st_q <= st_d;
    end
    always_comb begin
        st_d = st_q;
        case (st_q)
            IDLE:    st_d = div_op ? (rdata2 == 32'b0 ? DONE : BUSY) : IDLE;
            BUSY:    st_d = cnt_q == 5'd31 ? DONE : BUSY;
            DONE:    st_d = stall[2] ? DONE : IDLE;
            default: st_d = IDLE;
        endcase
    end
    always_comb begin
        stallreq_for_ex = (st_q == IDLE && div_op) || st_q == BUSY;
        div_load        = st_q == IDLE && div_op && rdata2 != 32'b0;
        div_zero        = st_q == IDLE && div_op && rdata2 == 32'b0;
        div_fin         = st_q == BUSY && cnt_q == 5'd31;
    end
    always_comb begin
        id_ex_d = (stall[2] && !stall[3]) ? '0 : !stall[2] ? id_to_ex_bus : id_ex_q;
        cnt_d   = div_load ? 5'd0 : st_q == BUSY ? cnt_q + 5'd1 : cnt_q;
        rem_d   = div_load ? 32'b0 : st_q == BUSY ? step_rem : rem_q;
        quo_d   = div_load ? mag_a : st_q == BUSY ? step_quo : quo_q;
        dvs_d   = div_load ? mag_b : dvs_q;
        nq_d    = div_load ? a_neg ^ b_neg : nq_q;
        nr_d    = div_load ? a_neg : nr_q;
        hi_d    = div_zero ? rdata1 : div_fin ? (nr_q ? -step_rem : step_rem)
                : (!stall[2] && is_mthi) ? rdata1 : hi_q;
        lo_d    = div_zero ? 32'hFFFF_FFFF : div_fin ? (nq_q ? -step_quo : step_quo)
                : (!stall[2] && is_mtlo) ? rdata1 : lo_q;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            id_ex_q <= '0;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            nq_q    <= 1'b0;
            nr_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            id_ex_q <= id_ex_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            nq_q    <= nq_d;
            nr_q    <= nr_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end
    assign ex_result       = is_mfhi ? hi_q : is_mflo ? lo_q : alu_res;
    assign ex_to_mem_bus   = {pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
    assign ex_to_rf_bus    = {rf_we, rf_waddr, ex_result};
    assign ex_is_load      = sel_rf_res;
    assign data_sram_en    = ram_en;
    assign data_sram_wen   = ram_wen;
    assign data_sram_addr  = alu_res;
    assign data_sram_wdata = rdata2;
    logic unused_bits;
    assign unused_bits = ^{stall[5:4], stall[1:0], inst[25:16]};
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
    logic clk = 1'b0, rst = 1'b1;
    logic [5:0] stall = '0;
    logic [158:0] id_to_ex_bus = '0;
    logic [75:0] ex_to_mem_bus;
    logic [37:0] ex_to_rf_bus;
    logic ex_is_load, stallreq_for_ex, data_sram_en;
    logic [3:0] data_sram_wen;
    logic [31:0] data_sram_addr, data_sram_wdata;
    int checks = 0, errors = 0;
    logic [31:0] m_hi = '0, m_lo = '0;
    logic [75:0] exp_mem;
    always #5 clk = ~clk;
    ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .id_to_ex_bus(id_to_ex_bus),
        .ex_to_mem_bus(ex_to_mem_bus), .ex_to_rf_bus(ex_to_rf_bus), .ex_is_load(ex_is_load),
        .stallreq_for_ex(stallreq_for_ex), .data_sram_en(data_sram_en),
        .data_sram_wen(data_sram_wen), .data_sram_addr(data_sram_addr),
        .data_sram_wdata(data_sram_wdata)
    );
    task automatic check(input string tag, input logic [75:0] got, input logic [75:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    function automatic logic [31:0] pick1(logic [2:0] s, logic [31:0] pc, logic [31:0] inst,
                                          logic [31:0] r1);
        if (s == 3'b001) return r1;
        if (s == 3'b010) return pc;
        if (s == 3'b100) return {27'b0, inst[10:6]};
        return 32'b0;
    endfunction
    function automatic logic [31:0] pick2(logic [3:0] s, logic [31:0] inst, logic [31:0] r2);
        if (s == 4'b0001) return r2;
        if (s == 4'b0010) return {{16{inst[15]}}, inst[15:0]};
        if (s == 4'b0100) return 32'd8;
        if (s == 4'b1000) return {16'b0, inst[15:0]};
        return 32'b0;
    endfunction
    // op: 0 add .. 11 lui, 12 = no operation
    function automatic logic [31:0] ref_alu(int op, logic [31:0] a, logic [31:0] b);
        case (op)
            0:  return a + b;
            1:  return a - b;
            2:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3:  return (a < b) ? 32'd1 : 32'd0;
            4:  return a & b;
            5:  return ~(a | b);
            6:  return a | b;
            7:  return a ^ b;
            8:  return b << a[4:0];
            9:  return b >> a[4:0];
            10: return $unsigned($signed(b) >>> a[4:0]);
            11: return {b[15:0], 16'b0};
            default: return 32'b0;
        endcase
    endfunction
    task automatic run(input int op, input logic [2:0] s1, input logic [3:0] s2,
                       input logic [31:0] pc, input logic [31:0] inst, input logic [31:0] r1,
                       input logic [31:0] r2, input logic en, input logic [3:0] wen,
                       input logic we, input logic [4:0] wa, input logic ld);
        logic [31:0] a, b, alu, res;
        logic [11:0] aop;
        logic sp;
        logic [5:0] fn;
        a = pick1(s1, pc, inst, r1);
        b = pick2(s2, inst, r2);
        alu = ref_alu(op, a, b);
        aop = (op < 12) ? (12'h800 >> op) : 12'h000;
        sp = inst[31:26] == 6'b0;
        fn = inst[5:0];
        res = (sp && fn == 6'h10) ? m_hi : (sp && fn == 6'h12) ? m_lo : alu;
        exp_mem = {pc, en, wen, ld, we, wa, res};
        id_to_ex_bus = {pc, inst, aop, s1, s2, en, wen, we, wa, ld, r1, r2};
        stall = '0;
        @(posedge clk); #1;
        check("mem_bus", ex_to_mem_bus, exp_mem);
        check("rf_bus", ex_to_rf_bus, {38'b0, we, wa, res});
        check("sram_en", data_sram_en, en);
        check("sram_wen", data_sram_wen, wen);
        check("sram_addr", data_sram_addr, alu);
        check("sram_wdata", data_sram_wdata, r2);
        check("is_load", ex_is_load, ld);
        check("stallreq", stallreq_for_ex, sp && (fn == 6'h1a || fn == 6'h1b));
        if (sp && fn == 6'h11) m_hi = r1;
        if (sp && fn == 6'h13) m_lo = r1;
    endtask
    task automatic do_div(input logic [31:0] a, input logic [31:0] b, input logic sg);
        int n;
        longint q, r;
        run(12, 3'b001, 4'b0001, 32'h0, {26'b0, sg ? 6'h1a : 6'h1b}, a, b, 1'b0, 4'h0, 1'b0,
            5'd0, 1'b0);
        n = 0;
        while (stallreq_for_ex && n < 100) begin
            stall = 6'b001111;
            @(posedge clk); #1;
            n++;
        end
        stall = '0;
        check("div_stall_cycles", 76'(n), (b == 0) ? 76'd1 : 76'd33);
        if (b == 0) begin
            m_lo = 32'hFFFF_FFFF;
            m_hi = a;
        end else if (sg) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            m_lo = q[31:0];
            m_hi = r[31:0];
        end else begin
            q = {32'b0, a} / {32'b0, b};
            r = {32'b0, a} % {32'b0, b};
            m_lo = q[31:0];
            m_hi = r[31:0];
        end
        run(12, 3'b000, 4'b0000, 32'h40, {26'b0, 6'h10}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd3,
            1'b0);
        run(12, 3'b000, 4'b0000, 32'h44, {26'b0, 6'h12}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd4,
            1'b0);
    endtask
    task automatic check_zero(input string tag);
        check({tag, "_mem"}, ex_to_mem_bus, 76'b0);
        check({tag, "_rf"}, ex_to_rf_bus, 76'b0);
        check({tag, "_sram"}, {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
              76'b0);
        check({tag, "_ld_stall"}, {ex_is_load, stallreq_for_ex}, 76'b0);
    endtask
    initial begin
        logic [75:0] held;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;
        // ori r1, r0, 0x1234
        run(6, 3'b001, 4'b1000, 32'hBFC0_0000, {6'h0d, 5'd0, 5'd1, 16'h1234}, 32'h0, 32'h0,
            1'b0, 4'h0, 1'b1, 5'd1, 1'b0);
        check("ori_lit", ex_to_rf_bus, {38'b0, 1'b1, 5'd1, 32'h0000_1234});
        run(11, 3'b000, 4'b0010, 32'h4, {6'h0f, 5'd0, 5'd2, 16'h8000}, 32'h0, 32'h0, 1'b0,
            4'h0, 1'b1, 5'd2, 1'b0);
        check("lui_lit", ex_to_mem_bus[31:0], 32'h8000_0000);
        run(1, 3'b001, 4'b0001, 32'h8, {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h23}, 32'd5, 32'd7,
            1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        check("sub_lit", ex_to_mem_bus[31:0], 32'hFFFF_FFFE);
        run(2, 3'b001, 4'b0001, 32'hC, {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2a}, 32'hFFFF_FFFF,
            32'd1, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        check("slt_lit", ex_to_mem_bus[31:0], 32'd1);
        run(3, 3'b001, 4'b0001, 32'h10, {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h2b}, 32'hFFFF_FFFF,
            32'd1, 1'b0, 4'h0, 1'b1, 5'd3, 1'b0);
        check("sltu_lit", ex_to_mem_bus[31:0], 32'd0);
        // store: sw with base 0x100, offset 8
        run(0, 3'b001, 4'b0010, 32'h14, {6'h2b, 5'd1, 5'd2, 16'd8}, 32'h100, 32'hAB, 1'b1,
            4'hF, 1'b0, 5'd0, 1'b0);
        check("store_lit", {data_sram_addr, data_sram_wdata}, {12'b0, 32'h108, 32'hAB});
        do_div(32'hFFFF_FFF9, 32'd2, 1'b1);
        check("div_lit", {m_hi, m_lo}, {12'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD});
        do_div(32'hFFFF_FFFF, 32'd16, 1'b0);
        check("divu_lit", {m_hi, m_lo}, {12'b0, 32'h0000_000F, 32'h0FFF_FFFF});
        do_div(32'h1234_5678, 32'd0, 1'b1);
        do_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        for (int i = 0; i < 6; i++) do_div($urandom, $urandom_range(1, 3) == 1 ? 32'($urandom_range(1, 9)) : $urandom, 1'($urandom));
        // mthi/mtlo followed by reads
        run(12, 3'b000, 4'b0000, 32'h50, {26'b0, 6'h11}, 32'hCAFE_0001, 32'h0, 1'b0, 4'h0, 1'b0,
            5'd0, 1'b0);
        run(12, 3'b000, 4'b0000, 32'h54, {26'b0, 6'h13}, 32'hBEEF_0002, 32'h0, 1'b0, 4'h0, 1'b0,
            5'd0, 1'b0);
        run(12, 3'b000, 4'b0000, 32'h58, {26'b0, 6'h10}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd5,
            1'b0);
        check("mfhi_lit", ex_to_mem_bus[31:0], 32'hCAFE_0001);
        run(12, 3'b000, 4'b0000, 32'h5C, {26'b0, 6'h12}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd6,
            1'b0);
        check("mflo_lit", ex_to_mem_bus[31:0], 32'hBEEF_0002);
        for (int i = 0; i < 60; i++)
            run($urandom_range(0, 12), 3'(1 << $urandom_range(0, 3)), 4'(1 << $urandom_range(0, 4)),
                $urandom, {6'($urandom_range(1, 63)), 26'($urandom)}, $urandom, $urandom,
                1'($urandom), 4'($urandom), 1'($urandom), 5'($urandom), 1'($urandom));
        // hold: register keeps its instruction while EX and MEM both stop
        run(7, 3'b001, 4'b0001, 32'h60, {6'h0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h26}, 32'hF0F0_1234,
            32'h0FF0_4321, 1'b0, 4'h0, 1'b1, 5'd7, 1'b1);
        held = exp_mem;
        id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom};
        stall = 6'b001111;
        @(posedge clk); #1;
        check("hold", ex_to_mem_bus, held);
        // bubble: EX stops but MEM runs
        id_to_ex_bus = {$urandom, $urandom, $urandom, $urandom, $urandom} | 159'h1;
        stall = 6'b000111;
        @(posedge clk); #1;
        check_zero("bubble");
        // reset in the middle of a divide
        run(12, 3'b001, 4'b0001, 32'h0, {26'b0, 6'h1a}, 32'd100, 32'd3, 1'b0, 4'h0, 1'b0, 5'd0,
            1'b0);
        stall = 6'b001111;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        stall = '0;
        id_to_ex_bus = '0;
        @(posedge clk); #1;
        rst = 1'b0;
        check_zero("mid_div_reset");
        m_hi = '0;
        m_lo = '0;
        run(12, 3'b000, 4'b0000, 32'h70, {26'b0, 6'h10}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd8,
            1'b0);
        run(12, 3'b000, 4'b0000, 32'h74, {26'b0, 6'h12}, 32'h0, 32'h0, 1'b0, 4'h0, 1'b1, 5'd9,
            1'b0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_stage.md
Name: ex_stage

Overview:
- Execute stage of the 5-stage MIPS pipeline. Sits directly downstream of the decode stage and consumes its 159-bit decode-to-execute bus.
- Holds the decode/execute pipeline register, the ALU and HI/LO registers, and a 32-cycle iterative divider for div/divu.
- Drives the data SRAM request, the execute/memory bus, and the execute forwarding bus back to decode.
- Raises a stall request while a divide is in flight.

Parameters:
ID_TO_EX_WD, 159, width of decode bus {pc[158:127], inst[126:95], alu_op[94:83], sel_alu_src1[82:80], sel_alu_src2[79:76], data_ram_en[75], data_ram_wen[74:71], rf_we[70], rf_waddr[69:65], sel_rf_res[64], rdata1[63:32], rdata2[31:0]}
EX_TO_MEM_WD, 76, width of {pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0]}
EX_TO_RF_WD, 38, width of {rf_we[37], rf_waddr[36:32], ex_result[31:0]}
StallBus, 6, stall vector width; Stop=1, NoStop=0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  6  pipeline stall vector; bit 2 = EX, bit 3 = MEM
id_to_ex_bus  in  159  decoded instruction from decode stage
ex_to_mem_bus  out  76  result bundle to memory stage
ex_to_rf_bus  out  38  forwarding bundle to decode stage
ex_is_load  out  1  registered instruction is a load (sel_rf_res=1); decode uses it for load-use stall
stallreq_for_ex  out  1  request to freeze IF/ID/EX while divider is busy
data_sram_en  out  1  data SRAM enable
data_sram_wen  out  4  byte write enables
data_sram_addr  out  32  data SRAM address
data_sram_wdata  out  32  store data

Behaviour:
- Reset: pipeline register, HI, LO and divider datapath all cleared to 0; FSM goes to IDLE. All outputs are therefore 0.
- Pipeline register update, in priority order on posedge clk:
  - rst: clear.
  - stall[2]=Stop and stall[3]=NoStop: load 0 (bubble).
  - stall[2]=NoStop: load id_to_ex_bus.
  - Otherwise: hold.
- Operand 1 select (one-hot): src1[0]=rdata1, src1[1]=pc, src1[2]={27'b0, inst[10:6]}; none set gives 0.
- Operand 2 select (one-hot): src2[0]=rdata2, src2[1]=sign-extended inst[15:0], src2[2]=32'd8, src2[3]=zero-extended inst[15:0]; none set gives 0.
- alu_op bit order, MSB to LSB: add, sub, slt, sltu, and, nor, or, xor, sll, srl, sra, lui.
  - add/sub: mod 2^32, no overflow trap.
  - slt: signed compare; sltu: unsigned compare.
  - Shifts: shift amount = op1[4:0], value shifted = op2.
  - lui: op2<<16.
  - alu_op=0: result 0.
- Special ops decoded from inst when opcode=000000:
  - func 010000 mfhi: ex_result=HI.
  - func 010010 mflo: ex_result=LO.
  - func 010001 mthi: HI<=rdata1.
  - func 010011 mtlo: LO<=rdata1.
  - mthi/mtlo write on the edge where stall[2]=NoStop.
- Divide: func 011010 = div (signed), 011011 = divu.
- Divider FSM states:
  - IDLE:
    - Divide in the register with divisor≠0: latch operand magnitudes, counter=0, go to BUSY.
    - Divide with divisor=0: go directly to DONE with LO=32'hFFFFFFFF, HI=dividend.
  - BUSY: one restoring shift-subtract step per cycle. After the step with counter=31, write HI=remainder and LO=quotient, then go to DONE. Total is 32 BUSY cycles.
  - DONE: stay until stall[2]=NoStop, then go to IDLE. This prevents the held divide from restarting.
- Signed divide fixup:
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
- stallreq_for_ex is combinational: high when a divide is in the register and state is IDLE, or when state is BUSY. It is low in DONE.
- mfhi/mflo immediately after a divide see the new values, because HI/LO are written on DONE entry.
- ex_result = special-op result if applicable, else ALU result.
- Data SRAM request (combinational from the register):
  - data_sram_en = data_ram_en.
  - data_sram_wen = data_ram_wen.
  - data_sram_addr = ALU result.
  - data_sram_wdata = rdata2.
- ex_to_rf_bus = {rf_we, rf_waddr, ex_result}. It is not gated for loads; decode must stall on ex_is_load.
- ex_to_mem_bus is combinational from the register; a bubble yields all zeros.
- Reset mid-divide: FSM returns to IDLE; HI/LO cleared; no partial write.

Test Plan:
- ori r1,r0,0x1234 (alu_op or, src1[0], src2[3], rdata1=0), stall=0 -> next cycle ex_result=0x00001234, ex_to_rf_bus={1,5'd1,0x00001234}.
- lui (src2[1], imm 0x8000) -> ex_result=0x80000000. sub 5-7 -> 0xFFFFFFFE. slt -1<1 -> 1; sltu -1<1 -> 0.
- div -7/2 -> stallreq_for_ex high for 33 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. A following mflo gives ex_result=0xFFFFFFFD.
- divu 0xFFFFFFFF/16 -> LO=0x0FFFFFFF, HI=0xF. Divide by zero -> 1 stall cycle, LO=0xFFFFFFFF, HI=dividend.
- stall=6'b000111 with a valid bus -> EX register becomes a bubble; all outputs 0. stall=6'b001111 -> register holds.
- Store (data_ram_en=1, wen=4'hF, rdata1=0x100, imm=8, rdata2=0xAB) -> addr=0x108, wdata=0xAB. Assert rst mid-divide -> IDLE, outputs 0.
